// File: rtl/purge_switch_ctrl.sv
// purge_switch_ctrl: switch bank ahead of the threshold voter; permanently purges any
// module that disagrees with the fed-back vote for DIS_THR consecutive valid samples.
module purge_switch_ctrl #(
    parameter int N        = 6,
    parameter int DIS_THR  = 3,
    parameter int CW       = 2,
    parameter int FAIL_MIN = 3,
    parameter int AW       = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  i_mod_out,
    input  logic          i_sample_en,
    input  logic          i_vote,
    input  logic          i_clear_purge,
    output logic [N-1:0]  o_sw_out,
    output logic [N-1:0]  o_purged,
    output logic [AW-1:0] o_active_cnt,
    output logic          o_purge_evt,
    output logic          o_fail
);
    typedef enum logic [1:0] {RUN, DEGRADED, FAILED} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [N-1:0]  r_purged;
    logic [N-1:0]  w_upd;
    logic [N-1:0]  w_mis;
    logic [N-1:0]  w_new;
    logic [CW-1:0] r_cnt [N];
    logic [AW-1:0] r_active;
    logic [AW-1:0] w_active_nxt;
    logic [AW-1:0] w_new_cnt;
    logic          r_evt;
    logic          r_fail;

    // A counter only ever reaches DIS_THR on the purging sample, so "saturation" is the purge itself.
    always_comb begin
        w_new_cnt = '0;
        for (int i = 0; i < N; i++) begin
            w_upd[i]  = i_sample_en && !r_purged[i] && (r_state != FAILED);
            w_mis[i]  = i_mod_out[i] != i_vote;
            w_new[i]  = w_upd[i] && w_mis[i] && (r_cnt[i] == CW'(DIS_THR - 1));
            w_new_cnt = w_new_cnt + AW'(w_new[i]);
        end
        w_active_nxt = r_active - w_new_cnt;
        w_state_nxt  = (w_active_nxt < AW'(FAIL_MIN)) ? FAILED :
                       (w_active_nxt < AW'(N))        ? DEGRADED : RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_purged <= '0;
            r_active <= AW'(N);
            r_state  <= RUN;
            r_evt    <= 1'b0;
            r_fail   <= 1'b0;
            for (int i = 0; i < N; i++) r_cnt[i] <= '0;
        end else if (i_clear_purge) begin
            r_purged <= '0;
            r_active <= AW'(N);
            r_state  <= RUN;
            r_evt    <= 1'b0;
            r_fail   <= 1'b0;
            for (int i = 0; i < N; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++)
                if (w_upd[i]) r_cnt[i] <= (w_mis[i] && !w_new[i]) ? r_cnt[i] + CW'(1) : '0;
            r_purged <= r_purged | w_new;
            r_active <= w_active_nxt;
            r_state  <= w_state_nxt;
            r_evt    <= |w_new;
            r_fail   <= w_state_nxt == FAILED;
        end
    end

    assign o_sw_out     = i_mod_out & ~r_purged;
    assign o_purged     = r_purged;
    assign o_active_cnt = r_active;
    assign o_purge_evt  = r_evt;
    assign o_fail       = r_fail;
endmodule

// File: doc/purge_switch_ctrl.md
Name: purge_switch_ctrl

Overview:
- Sequential purge controller and switch bank for the self-purging redundant adder; sits directly upstream of the threshold voter.
- Gates the N raw module outputs into the voter and compares each active module against the voter's fed-back output.
- Permanently excludes (purges) any module that disagrees for DIS_THR consecutive valid samples; a purged module drives 0 into the voter.
- Tracks the active-module count and raises a sticky failure flag when too few modules remain.

Parameters:
- N, 6, number of redundant modules (must match the voter's N)
- DIS_THR, 3, consecutive valid disagreements that purge a module (1..2^CW-1)
- CW, 2, per-module disagreement counter width
- FAIL_MIN, 3, minimum active modules for correct voting; below this the block enters FAILED
- AW, 3, active-count width, equal to ceil(log2(N+1))

Ports:
- clk, in, 1, system clock, rising edge
- rst_n, in, 1, asynchronous active-low reset
- mod_out, in, N, raw outputs of the redundant modules
- sample_en, in, 1, current mod_out/vote pair is valid and is evaluated this cycle
- vote, in, 1, voter output, fed back combinationally from the voter
- clear_purge, in, 1, synchronous maintenance re-enable of all modules
- sw_out, out, N, gated outputs to the voter: mod_out & ~purged
- purged, out, N, registered sticky purge flags
- active_cnt, out, AW, registered count of non-purged modules
- purge_evt, out, 1, one-cycle pulse on any new purge
- fail, out, 1, registered; high while in state FAILED

Behaviour:
- Reset (rst_n low, asynchronous):
  - purged=0, all counters=0, active_cnt=N, purge_evt=0, fail=0, state=RUN.
  - sw_out then equals mod_out.
  - Release of rst_n is used synchronously.
- sw_out is combinational from mod_out and registered purged, so there is no combinational loop through vote.
- States: RUN (active_cnt=N), DEGRADED (FAIL_MIN<=active_cnt<N), FAILED (active_cnt<FAIL_MIN).
  - State is recomputed each edge from the next active_cnt.
  - FAILED is sticky until clear_purge or reset.
- Per-module counter i, updated on a rising edge with sample_en=1, purged[i]=0, state!=FAILED:
  - mod_out[i]!=vote: cnt[i] increments, saturating at DIS_THR.
  - mod_out[i]==vote: cnt[i] clears to 0.
- Purge:
  - When a sample drives cnt[i] to DIS_THR, purged[i] sets on that same edge.
  - Effect on sw_out is visible the following cycle, i.e. one cycle after the DIS_THR-th disagreeing sample.
- sample_en=0: counters and flags hold; non-consecutive disagreements never accumulate across an agreeing valid sample.
- Simultaneous purges: any number of modules may purge on one edge.
  - active_cnt decreases by the popcount of new purges.
  - purge_evt pulses exactly once for that edge.
- Entering FAILED: purges that cause the transition still take effect. From the next edge on, all counters freeze and no further purges occur.
- Purged modules: counter held at 0, flag never clears except by clear_purge or reset.
- clear_purge=1 at an edge:
  - purged=0, counters=0, active_cnt=N, state=RUN, fail=0, purge_evt=0.
  - Has priority over sample_en in the same cycle.
- purge_evt is registered, high for exactly one cycle per purging edge; back-to-back purge edges give back-to-back pulses.
- Reset asserted mid-count discards all partial counts immediately.

Test Plan:
- Reset released with mod_out=6'b101010 -> sw_out=6'b101010, purged=0, active_cnt=6, fail=0, purge_evt=0.
- Module 2 disagrees with vote on 3 consecutive sample_en cycles -> purged=6'b000100 after the 3rd edge, purge_evt pulses one cycle, active_cnt=5, sw_out[2]=0 thereafter.
- Module 4 sequence: disagree, disagree, agree, disagree, disagree, with sample_en gaps inserted -> no purge, purged[4]=0, active_cnt unchanged.
- Modules 0, 1 and 3 reach DIS_THR on the same edge -> purged=6'b001011, active_cnt=3, fail=0, single purge_evt pulse. Module 5 then purges -> active_cnt=2, fail=1. Module 4 disagreeing a further 5 times -> no change.
- From FAILED, assert clear_purge together with sample_en and a disagreement -> purged=0, active_cnt=6, fail=0, all counters 0.
- Module 1 at cnt=2, rst_n pulsed low mid-cycle -> outputs return to reset values immediately. One further disagreement after release -> no purge, because the count restarts at 1.
